ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test initiator for the DFFRAM macros, starting with RAM2x8.
- Drives the RAM's single clk/D/addr/we/Q port with a March C- sequence and reads back every word.
- Reports pass/fail and captures the first failing address and data.
- Sits beside each RAM instance and is muxed onto the RAM port by the integrating wrapper while busy.

Parameters:
- WORDS, 2, number of RAM words; must be 2 or more; need not be a power of two.
- ADDR_W, 1, RAM address width; must satisfy 2**ADDR_W >= WORDS.
- WIDTH, 8, RAM word width.

Ports:
- clk  input  1  system clock; the RAM and the BIST share this clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled on rising clk in IDLE or DONE.
- busy  output  1  high while the march runs.
- done  output  1  high from the end of a run until the next accepted start.
- fail  output  1  sticky; high once any read mismatches in the current run.
- fail_addr  output  ADDR_W  address of the first mismatch.
- fail_data  output  WIDTH  ram_Q value at the first mismatch.
- ram_addr  output  ADDR_W  RAM address.
- ram_D  output  WIDTH  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_Q  input  WIDTH  RAM read data; combinational from ram_addr.

Behaviour:
- Reset values: busy, done, fail, fail_addr, fail_data, ram_addr, ram_D and ram_we are all 0. Reset takes effect asynchronously, including mid-run; the FSM returns to IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1 at a clk edge.
  - DONE -> RUN when start=1 at a clk edge; this clears done and fail.
  - start is ignored in RUN.
- March C-: element list, with 0 = all-zeros word and 1 = all-ones word:
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- Sequencing:
  - One op per clk cycle.
  - Within an element, all ops for one address complete before the address advances.
  - "up" runs address 0 to WORDS-1; "down" runs WORDS-1 to 0.
  - Terminal count is compared explicitly against WORDS-1 and 0, with no power-of-two wrap.
- Run length is exactly 10*WORDS op cycles (20 for WORDS=2).
  - start accepted at edge k: busy=1 after edge k, and the first op is presented in cycle k..k+1.
  - At edge k+10*WORDS: busy=0, done=1, state=DONE.
- Write op: ram_we=1, ram_addr=current address, ram_D={WIDTH{pattern}}. The RAM writes at the closing edge.
- Read op:
  - ram_we=0, ram_addr=current address, ram_D=0.
  - At the closing edge, ram_Q is compared with {WIDTH{expected}}.
  - On mismatch with fail=0: set fail=1, fail_addr=address, fail_data=ram_Q.
  - Later mismatches do not update the capture registers.
  - The run always completes; there is no early abort.
- IDLE and DONE drive ram_we=0, ram_addr=0, ram_D=0. ram_we must never be 1 outside RAM state.
- fail_addr and fail_data hold their values through DONE and are cleared only by reset or an accepted start.

Decomposition:
- Shared package ram_bist_pkg holds:
  - the state encoding (IDLE/RUN/DONE);
  - the op encoding (NONE/R0/R1/W0/W1);
  - the element count (6) and per-element op count and direction constants.
- One sub-module, march_c_rom: purely combinational. Maps (element index, op index) to op code, op count and direction. This lets other march algorithms be swapped in later.

Test Plan:
Every scenario uses WORDS=2 and WIDTH=8, with a behavioural RAM model: write on posedge when we=1; Q combinational from addr.
- Reset with rst_n=0, then release -> all outputs 0, ram_we stays 0 for 5 idle cycles.
- Fault-free RAM, one-cycle start pulse:
  - busy=1 for exactly 20 cycles, then done=1, fail=0.
  - First four ops are: W 0x00@0, W 0x00@1, R@0 (Q=0x00), W 0xFF@0.
  - Last op is R@1 expecting 0x00.
- Stuck-at-0 on bit 3 of word 1 -> first mismatch at E2 r1@1; fail=1, fail_addr=1, fail_data=0xF7; run still ends with done at cycle 20.
- Coupling fault, where a write of 0xFF to word 0 sets bit 0 of word 1 -> mismatch at E1 r0@1; fail_addr=1, fail_data=0x01.
- start held high through RUN -> no restart until DONE. With start still high in DONE, a new run begins: done and fail clear, busy=1, and the run is again 20 cycles.
- rst_n pulsed low at cycle 7 of a run -> ram_we=0 and busy=0 immediately, before the next edge. The next start runs the full 20 cycles with fault-free result fail=0.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared encodings for the RAM march BIST: FSM states, op codes and per-element march constants.
// Pure declarations; no latency or backpressure of its own.
package ram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_R0   = 3'd1,
        OP_R1   = 3'd2,
        OP_W0   = 3'd3,
        OP_W1   = 3'd4
    } op_t;

    typedef logic [2:0] elem_idx_t;

    localparam int N_ELEM = 6;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [1:0] OPS_SINGLE = 2'd1;
    localparam logic [1:0] OPS_PAIR   = 2'd2;

    // March C-: E1..E4 are (read, write) pairs, E3/E4 walk addresses downward.
    function automatic logic elem_dir(input elem_idx_t e);
        return (e == 3'd3 || e == 3'd4) ? DIR_DOWN : DIR_UP;
    endfunction

    function automatic logic [1:0] elem_ops(input elem_idx_t e);
        return (e >= 3'd1 && e <= 3'd4) ? OPS_PAIR : OPS_SINGLE;
    endfunction

endpackage

// File: rtl/march_c_rom.sv
// March C- element table: (element, op index) -> op code, op count, address direction.
// Purely combinational; no backpressure.
import ram_bist_pkg::*;

module march_c_rom (
    input  logic [2:0] elem,
    input  logic       opi,
    output logic [2:0] op,
    output logic [1:0] nops,
    output logic       dir
);

    op_t op_sel;

    always_comb begin
        op_sel = OP_NONE;
        unique case (elem)
            3'd0:    op_sel = OP_W0;
            3'd1:    op_sel = opi ? OP_W1 : OP_R0;
            3'd2:    op_sel = opi ? OP_W0 : OP_R1;
            3'd3:    op_sel = opi ? OP_W1 : OP_R0;
            3'd4:    op_sel = opi ? OP_W0 : OP_R1;
            3'd5:    op_sel = OP_R0;
            default: op_sel = OP_NONE;
        endcase
    end

    assign op   = op_sel;
    assign nops = elem_ops(elem);
    assign dir  = elem_dir(elem);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator driving a single-port RAM and capturing the first mismatch.
// One op per cycle, 10*WORDS cycles per run; start is ignored while a run is in progress.
import ram_bist_pkg::*;

module ram_march_bist #(
    parameter int WORDS  = 2,
    parameter int ADDR_W = 1,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [WIDTH-1:0]  fail_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_D,
    output logic              ram_we,
    input  logic [WIDTH-1:0]  ram_Q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam elem_idx_t         LAST_ELEM = elem_idx_t'(N_ELEM - 1);

    state_t            state, state_nxt;
    elem_idx_t         elem;
    logic              opi;
    logic [ADDR_W-1:0] addr;

    logic [2:0]        op_raw;
    op_t               op;
    logic [1:0]        nops;
    logic              dir;

    logic              last_op, last_addr, last_elem, accept;
    logic              is_read, mismatch;
    logic [WIDTH-1:0]  exp_word;

    march_c_rom u_rom (
        .elem (elem),
        .opi  (opi),
        .op   (op_raw),
        .nops (nops),
        .dir  (dir)
    );

    assign op        = op_t'(op_raw);
    assign last_op   = ({1'b0, opi} == (nops - 2'd1));
    assign last_addr = (dir == DIR_DOWN) ? (addr == '0) : (addr == LAST_ADDR);
    assign last_elem = (elem == LAST_ELEM);
    assign accept    = (state != ST_RUN) && start;

    assign is_read  = (op == OP_R0) || (op == OP_R1);
    assign exp_word = (op == OP_R1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign mismatch = is_read && (ram_Q != exp_word);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_op && last_addr && last_elem) state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; the RAM port is parked at zero whenever no march is running
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_D    = '0;
        unique case (state)
            ST_RUN: begin
                busy     = 1'b1;
                ram_addr = addr;
                ram_we   = (op == OP_W0) || (op == OP_W1);
                ram_D    = (op == OP_W1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // March position: op within address, address within element, then element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem <= '0;
            opi  <= 1'b0;
            addr <= '0;
        end else if (accept) begin
            elem <= '0;
            opi  <= 1'b0;
            addr <= (elem_dir(3'd0) == DIR_DOWN) ? LAST_ADDR : '0;
        end else if (state == ST_RUN) begin
            if (!last_op) begin
                opi <= 1'b1;
            end else begin
                opi <= 1'b0;
                if (!last_addr) begin
                    addr <= (dir == DIR_DOWN) ? addr - 1'b1 : addr + 1'b1;
                end else if (!last_elem) begin
                    elem <= elem + 3'd1;
                    addr <= (elem_dir(elem + 3'd1) == DIR_DOWN) ? LAST_ADDR : '0;
                end
            end
        end
    end

    // First-mismatch capture; later mismatches leave the capture untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (accept) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == ST_RUN && mismatch && !fail) begin
            fail      <= 1'b1;
            fail_addr <= addr;
            fail_data <= ram_Q;
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist (WORDS=2, WIDTH=8) with a behavioural RAM and injectable faults.
module tb_ram_march_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, fail;
    logic [0:0] fail_addr;
    logic [7:0] fail_data;
    logic [0:0] ram_addr;
    logic [7:0] ram_D;
    logic       ram_we;
    logic [7:0] ram_Q;

    int total = 0;
    int bad   = 0;

    // 0 = fault-free, 1 = word1 bit3 stuck-at-0, 2 = write FF to word0 sets word1 bit0
    int fault = 0;

    logic [7:0] mem [2];

    logic       we_log   [128];
    logic [0:0] addr_log [128];
    logic [7:0] d_log    [128];
    logic [7:0] q_log    [128];

    ram_march_bist #(.WORDS(2), .ADDR_W(1), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .ram_addr  (ram_addr),
        .ram_D     (ram_D),
        .ram_we    (ram_we),
        .ram_Q     (ram_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_D;
            if (fault == 2 && ram_addr == 1'b0 && ram_D == 8'hFF)
                mem[1][0] <= 1'b1;
        end
    end

    always_comb begin
        ram_Q = mem[ram_addr];
        if (fault == 1 && ram_addr == 1'b1)
            ram_Q[3] = 1'b0;
    end

    // Pulse (or hold) start, then log every busy cycle; cyc counts cycles with busy=1.
    task automatic do_run(input bit hold, output int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            we_log[cyc]   = ram_we;
            addr_log[cyc] = ram_addr;
            d_log[cyc]    = ram_D;
            q_log[cyc]    = ram_Q;
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        #3;
        total++;
        if ({busy, done, fail, fail_addr, fail_data, ram_addr, ram_D, ram_we} !== 28'h0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b fail=%b fa=%h fd=%h ra=%h rd=%h we=%b, want all 0",
                     busy, done, fail, fail_addr, fail_data, ram_addr, ram_D, ram_we);
        end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (ram_we !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got we=%b busy=%b, want 0 0", i, ram_we, busy);
            end
        end
    endtask

    task automatic test_fault_free;
        int cyc;
        fault = 0;
        do_run(1'b0, cyc);
        total++;
        if (cyc != 20) begin
            bad++;
            $display("FAIL ff_busy_len: got %0d, want 20", cyc);
        end
        total++;
        if (done !== 1'b1 || fail !== 1'b0) begin
            bad++;
            $display("FAIL ff_end: got done=%b fail=%b, want 1 0", done, fail);
        end
        total++;
        if ({we_log[0], addr_log[0], d_log[0]} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL ff_op0: got we=%b a=%h d=%h, want W 00@0", we_log[0], addr_log[0], d_log[0]);
        end
        total++;
        if ({we_log[1], addr_log[1], d_log[1]} !== {1'b1, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL ff_op1: got we=%b a=%h d=%h, want W 00@1", we_log[1], addr_log[1], d_log[1]);
        end
        total++;
        if ({we_log[2], addr_log[2], d_log[2], q_log[2]} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL ff_op2: got we=%b a=%h d=%h q=%h, want R@0 q=00",
                     we_log[2], addr_log[2], d_log[2], q_log[2]);
        end
        total++;
        if ({we_log[3], addr_log[3], d_log[3]} !== {1'b1, 1'b0, 8'hFF}) begin
            bad++;
            $display("FAIL ff_op3: got we=%b a=%h d=%h, want W FF@0", we_log[3], addr_log[3], d_log[3]);
        end
        total++;
        if ({we_log[19], addr_log[19], d_log[19], q_log[19]} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL ff_last: got we=%b a=%h d=%h q=%h, want R@1 q=00",
                     we_log[19], addr_log[19], d_log[19], q_log[19]);
        end
        total++;
        if (ram_we !== 1'b0 || ram_addr !== 1'b0 || ram_D !== 8'h00) begin
            bad++;
            $display("FAIL ff_done_port: got we=%b a=%h d=%h, want 0 0 00", ram_we, ram_addr, ram_D);
        end
    endtask

    task automatic test_stuck_at;
        int cyc;
        fault = 1;
        do_run(1'b0, cyc);
        total++;
        if (cyc != 20 || done !== 1'b1) begin
            bad++;
            $display("FAIL sa0_len: got cyc=%0d done=%b, want 20 1", cyc, done);
        end
        total++;
        if ({fail, fail_addr, fail_data} !== {1'b1, 1'b1, 8'hF7}) begin
            bad++;
            $display("FAIL sa0_capture: got fail=%b addr=%h data=%h, want 1 1 F7", fail, fail_addr, fail_data);
        end
        fault = 0;
    endtask

    task automatic test_coupling;
        int cyc;
        fault = 2;
        do_run(1'b0, cyc);
        total++;
        if (cyc != 20 || done !== 1'b1) begin
            bad++;
            $display("FAIL cf_len: got cyc=%0d done=%b, want 20 1", cyc, done);
        end
        total++;
        if ({fail, fail_addr, fail_data} !== {1'b1, 1'b1, 8'h01}) begin
            bad++;
            $display("FAIL cf_capture: got fail=%b addr=%h data=%h, want 1 1 01", fail, fail_addr, fail_data);
        end
        fault = 0;
    endtask

    task automatic test_start_held;
        int cyc;
        fault = 1;
        do_run(1'b1, cyc);
        total++;
        if (cyc != 20 || done !== 1'b1 || fail !== 1'b1) begin
            bad++;
            $display("FAIL held_run1: got cyc=%0d done=%b fail=%b, want 20 1 1", cyc, done, fail);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || fail !== 1'b0) begin
            bad++;
            $display("FAIL held_restart: got busy=%b done=%b fail=%b, want 1 0 0", busy, done, fail);
        end
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++;
        if (cyc != 20 || done !== 1'b1 || fail !== 1'b1) begin
            bad++;
            $display("FAIL held_run2: got cyc=%0d done=%b fail=%b, want 20 1 1", cyc, done, fail);
        end
        fault = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int cyc;
        fault = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: got %b, want 1", busy);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got we=%b busy=%b done=%b, want 0 0 0", ram_we, busy, done);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_run(1'b0, cyc);
        total++;
        if (cyc != 20 || done !== 1'b1 || fail !== 1'b0) begin
            bad++;
            $display("FAIL mid_rerun: got cyc=%0d done=%b fail=%b, want 20 1 0", cyc, done, fail);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_coupling();
        test_start_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
